// File: rtl/cam_pkg.sv
// Shared constants, types and helpers for the IR camera to framebuffer mapper.
package cam_pkg;

  // Camera geometry as reported by the IR camera reader.
  localparam int CAM_W = 1024;
  localparam int CAM_H = 768;
  localparam logic [9:0] CAM_NO_BLOB = 10'h3FF;

  // Screen geometry and framebuffer address width.
  localparam int SCREEN_W   = 640;
  localparam int SCREEN_H   = 480;
  localparam int PIX_ADDR_W = 19;

  // Mapper FSM encoding.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SUM   = 2'd1;
  localparam logic [1:0] S_SCALE = 2'd2;
  localparam logic [1:0] S_EMIT  = 2'd3;

  // One camera position sample.
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } cam_sample_t;

  // Multiply by 5/8 with truncation: (a*4 + a) >> 3, no multiplier needed.
  function automatic logic [9:0] scale_5_8(input logic [9:0] a);
    logic [12:0] p;
    p = {3'b000, a} + {1'b0, a, 2'b00};
    return p[12:3];
  endfunction

endpackage

// File: rtl/cam_pixel_mapper_if.sv
// Framebuffer pixel-write request bus (valid/ready).
interface cam_pixel_mapper_if;
  import cam_pkg::*;

  logic [PIX_ADDR_W-1:0] pix_addr;
  logic [9:0]            pix_x;
  logic [8:0]            pix_y;
  logic                  pix_valid;
  logic                  pix_ready;

  // Producer side: the mapper.
  modport master (
    output pix_addr, pix_x, pix_y, pix_valid,
    input  pix_ready
  );

  // Consumer side: the framebuffer write arbiter.
  modport slave (
    input  pix_addr, pix_x, pix_y, pix_valid,
    output pix_ready
  );
endinterface

// File: rtl/cam_avg4.sv
// Circular sample history with running per-axis sums and a fill counter.
module cam_avg4 #(
  parameter int WIN_LOG2 = 2,
  parameter int SUM_W    = 10 + WIN_LOG2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 push,
  input  logic                 clear,
  input  cam_pkg::cam_sample_t sample,
  output logic [SUM_W-1:0]     sum_x,
  output logic [SUM_W-1:0]     sum_y,
  output logic                 full
);
  import cam_pkg::*;

  localparam int WIN = 1 << WIN_LOG2;
  localparam logic [WIN_LOG2:0] WIN_CNT = (WIN_LOG2 + 1)'(WIN);
  localparam logic [WIN_LOG2:0] WIN_PRE = (WIN_LOG2 + 1)'(WIN - 1);

  logic [9:0]          hist_x_reg [WIN];
  logic [9:0]          hist_y_reg [WIN];
  logic [WIN_LOG2-1:0] wr_ptr_reg;
  logic [WIN_LOG2:0]   fill_reg;
  logic [SUM_W-1:0]    sum_x_reg;
  logic [SUM_W-1:0]    sum_y_reg;
  logic [9:0]          old_x;
  logic [9:0]          old_y;

  // The slot about to be overwritten holds the oldest sample (zero until filled).
  assign old_x = hist_x_reg[wr_ptr_reg];
  assign old_y = hist_y_reg[wr_ptr_reg];

  assign sum_x = sum_x_reg;
  assign sum_y = sum_y_reg;

  // While pushing, report fullness as it will be once this push lands.
  assign full = push ? (fill_reg >= WIN_PRE) : (fill_reg == WIN_CNT);

  // History, running sums and fill count; clear wipes everything so the sums stay consistent.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WIN; i++) begin
        hist_x_reg[i] <= '0;
        hist_y_reg[i] <= '0;
      end
      wr_ptr_reg <= '0;
      fill_reg   <= '0;
      sum_x_reg  <= '0;
      sum_y_reg  <= '0;
    end else if (clear) begin
      for (int i = 0; i < WIN; i++) begin
        hist_x_reg[i] <= '0;
        hist_y_reg[i] <= '0;
      end
      wr_ptr_reg <= '0;
      fill_reg   <= '0;
      sum_x_reg  <= '0;
      sum_y_reg  <= '0;
    end else if (push) begin
      hist_x_reg[wr_ptr_reg] <= sample.x;
      hist_y_reg[wr_ptr_reg] <= sample.y;
      sum_x_reg  <= sum_x_reg + SUM_W'(sample.x) - SUM_W'(old_x);
      sum_y_reg  <= sum_y_reg + SUM_W'(sample.y) - SUM_W'(old_y);
      wr_ptr_reg <= wr_ptr_reg + WIN_LOG2'(1);
      if (fill_reg != WIN_CNT) begin
        fill_reg <= fill_reg + (WIN_LOG2 + 1)'(1);
      end
    end
  end

endmodule

// File: rtl/cam_pixel_mapper.sv
// Camera blob position to framebuffer pixel-write requests: averaging, scaling, dedup, handshake.
module cam_pixel_mapper #(
  parameter int WIN_LOG2   = 2,
  parameter int MISS_LIMIT = 3,
  parameter int SCREEN_W   = cam_pkg::SCREEN_W,
  parameter int SCREEN_H   = cam_pkg::SCREEN_H
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [9:0]         cam_x,
  input  logic [9:0]         cam_y,
  input  logic               cam_valid,
  cam_pixel_mapper_if.master pix,
  output logic               pen_down,
  output logic [7:0]         drop_count
);
  import cam_pkg::*;

  localparam int SUM_W  = 10 + WIN_LOG2;
  localparam int MISS_W = $clog2(MISS_LIMIT + 1);
  localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(MISS_LIMIT);
  localparam logic [MISS_W-1:0] MISS_PRE = MISS_W'(MISS_LIMIT - 1);
  localparam logic [9:0] X_MAX = 10'(SCREEN_W - 1);
  localparam logic [9:0] Y_MAX = 10'(SCREEN_H - 1);

  logic [1:0]            state_reg;
  logic [MISS_W-1:0]     miss_cnt_reg;
  cam_sample_t           sample_reg;
  logic                  pen_down_reg;
  logic [7:0]            drop_count_reg;
  logic [PIX_ADDR_W-1:0] last_addr_reg;
  logic [PIX_ADDR_W-1:0] pix_addr_reg;
  logic [9:0]            pix_x_reg;
  logic [8:0]            pix_y_reg;
  logic                  pix_valid_reg;

  logic                  no_blob;
  logic                  miss_final;
  logic                  avg_push;
  logic                  avg_clear;
  logic [SUM_W-1:0]      sum_x;
  logic [SUM_W-1:0]      sum_y;
  logic                  hist_full;

  logic [9:0]            ax, ay, sx_raw, sy_raw, sx;
  logic [8:0]            sy;
  logic [PIX_ADDR_W-1:0] sy_ext;
  logic [PIX_ADDR_W-1:0] row_term [PIX_ADDR_W];
  logic [PIX_ADDR_W-1:0] row_base;
  logic [PIX_ADDR_W-1:0] addr_calc;

  assign no_blob    = (cam_x == CAM_NO_BLOB) && (cam_y == CAM_NO_BLOB);
  assign miss_final = (miss_cnt_reg >= MISS_PRE);
  assign avg_push   = (state_reg == S_SUM);
  assign avg_clear  = (state_reg == S_IDLE) && cam_valid && no_blob && miss_final;

  cam_avg4 #(
    .WIN_LOG2 (WIN_LOG2),
    .SUM_W    (SUM_W)
  ) u_avg (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (avg_push),
    .clear   (avg_clear),
    .sample  (sample_reg),
    .sum_x   (sum_x),
    .sum_y   (sum_y),
    .full    (hist_full)
  );

  // Average, scale by 5/8 and clamp to the visible screen.
  always_comb begin
    ax     = 10'(sum_x >> WIN_LOG2);
    ay     = 10'(sum_y >> WIN_LOG2);
    sx_raw = scale_5_8(ax);
    sy_raw = scale_5_8(ay);
    sx     = (sx_raw > X_MAX) ? X_MAX : sx_raw;
    sy     = 9'((sy_raw > Y_MAX) ? Y_MAX : sy_raw);
  end

  assign sy_ext = PIX_ADDR_W'(sy);

  // Row stride as shift-add: one shifted copy of sy per set bit of SCREEN_W.
  for (genvar gi = 0; gi < PIX_ADDR_W; gi++) begin : g_stride
    assign row_term[gi] = (((SCREEN_W >> gi) & 1) != 0) ? (sy_ext << gi) : '0;
  end

  // Sum the stride terms into the row base address.
  always_comb begin
    row_base = '0;
    for (int i = 0; i < PIX_ADDR_W; i++) begin
      row_base = row_base + row_term[i];
    end
  end

  assign addr_calc = row_base + PIX_ADDR_W'(sx);

  // Count samples that arrive while busy, including the accepting handshake cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_count_reg <= '0;
    end else if (cam_valid && (state_reg != S_IDLE) && (drop_count_reg != 8'hFF)) begin
      drop_count_reg <= drop_count_reg + 8'd1;
    end
  end

  // Main sequencer: sample intake, miss tracking, scaling, dedup and request handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= S_IDLE;
      miss_cnt_reg  <= '0;
      sample_reg    <= '0;
      pen_down_reg  <= 1'b0;
      last_addr_reg <= '1;
      pix_addr_reg  <= '0;
      pix_x_reg     <= '0;
      pix_y_reg     <= '0;
      pix_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (cam_valid) begin
            if (no_blob) begin
              if (miss_cnt_reg != MISS_MAX) begin
                miss_cnt_reg <= miss_cnt_reg + MISS_W'(1);
              end
              if (miss_final) begin
                pen_down_reg <= 1'b0;
              end
            end else begin
              miss_cnt_reg <= '0;
              sample_reg.x <= cam_x;
              sample_reg.y <= cam_y;
              state_reg    <= S_SUM;
            end
          end
        end
        S_SUM: begin
          state_reg <= hist_full ? S_SCALE : S_IDLE;
        end
        S_SCALE: begin
          pen_down_reg <= 1'b1;
          if (addr_calc == last_addr_reg) begin
            state_reg <= S_IDLE;
          end else begin
            pix_addr_reg  <= addr_calc;
            pix_x_reg     <= sx;
            pix_y_reg     <= sy;
            pix_valid_reg <= 1'b1;
            state_reg     <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (pix.pix_ready) begin
            pix_valid_reg <= 1'b0;
            last_addr_reg <= pix_addr_reg;
            state_reg     <= S_IDLE;
          end
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign pix.pix_addr  = pix_addr_reg;
  assign pix.pix_x     = pix_x_reg;
  assign pix.pix_y     = pix_y_reg;
  assign pix.pix_valid = pix_valid_reg;
  assign pen_down      = pen_down_reg;
  assign drop_count    = drop_count_reg;

endmodule

// File: tb/tb_cam_pixel_mapper.sv
// Directed bench for cam_pixel_mapper: fill, dedup, pen-up, back-pressure, corners, async reset.
module tb_cam_pixel_mapper;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] cam_x;
  logic [9:0] cam_y;
  logic       cam_valid;
  logic       pen_down;
  logic [7:0] drop_count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  cam_pixel_mapper_if pif();

  cam_pixel_mapper dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cam_x      (cam_x),
    .cam_y      (cam_y),
    .cam_valid  (cam_valid),
    .pix        (pif),
    .pen_down   (pen_down),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    repeat (n) step();
  endtask

  // Strobe one sample, then watch 12 cycles for accepted requests.
  task automatic push_sample(input logic [9:0] x, input logic [9:0] y,
                             output int n_acc, output int lat,
                             output logic [18:0] a, output logic [9:0] px, output logic [8:0] py);
    n_acc = 0;
    lat   = -1;
    a     = '0;
    px    = '0;
    py    = '0;
    cam_x = x;
    cam_y = y;
    cam_valid = 1'b1;
    step();
    cam_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (pif.pix_valid && pif.pix_ready) begin
        if (lat < 0) begin
          lat = c;
          a   = pif.pix_addr;
          px  = pif.pix_x;
          py  = pif.pix_y;
        end
        n_acc++;
      end
      step();
    end
    $display("sample (%0d,%0d): accepts=%0d lat=%0d addr=%0d x=%0d y=%0d pen=%0d drops=%0d",
             x, y, n_acc, lat, a, px, py, pen_down, drop_count);
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    cam_valid = 1'b0;
    cam_x     = '0;
    cam_y     = '0;
    pif.pix_ready = 1'b1;
    gap(3);
    reset_n = 1'b1;
    gap(2);
    total_cnt++; if (pif.pix_valid !== 1'b0) $display("FAIL reset_pix_valid: got %0d want 0", pif.pix_valid); else pass_cnt++;
    total_cnt++; if (pif.pix_addr !== 19'd0) $display("FAIL reset_pix_addr: got %0d want 0", pif.pix_addr); else pass_cnt++;
    total_cnt++; if (pif.pix_x !== 10'd0) $display("FAIL reset_pix_x: got %0d want 0", pif.pix_x); else pass_cnt++;
    total_cnt++; if (pif.pix_y !== 9'd0) $display("FAIL reset_pix_y: got %0d want 0", pif.pix_y); else pass_cnt++;
    total_cnt++; if (pen_down !== 1'b0) $display("FAIL reset_pen_down: got %0d want 0", pen_down); else pass_cnt++;
    total_cnt++; if (drop_count !== 8'd0) $display("FAIL reset_drop_count: got %0d want 0", drop_count); else pass_cnt++;
  endtask

  task automatic test_fill_emit();
    int n, lat;
    logic [18:0] a;
    logic [9:0] px;
    logic [8:0] py;
    for (int i = 1; i <= 4; i++) begin
      push_sample(10'd512, 10'd384, n, lat, a, px, py);
      if (i < 4) begin
        total_cnt++; if (n !== 0) $display("FAIL fill_no_output_%0d: got %0d accepts want 0", i, n); else pass_cnt++;
      end else begin
        total_cnt++; if (n !== 1) $display("FAIL fill_accepts: got %0d want 1", n); else pass_cnt++;
        total_cnt++; if (lat !== 3) $display("FAIL fill_latency: got %0d want 3", lat); else pass_cnt++;
        total_cnt++; if (px !== 10'd320) $display("FAIL fill_pix_x: got %0d want 320", px); else pass_cnt++;
        total_cnt++; if (py !== 9'd240) $display("FAIL fill_pix_y: got %0d want 240", py); else pass_cnt++;
        total_cnt++; if (a !== 19'd153920) $display("FAIL fill_pix_addr: got %0d want 153920", a); else pass_cnt++;
        total_cnt++; if (pen_down !== 1'b1) $display("FAIL fill_pen_down: got %0d want 1", pen_down); else pass_cnt++;
      end
      gap(107);
    end
  endtask

  task automatic test_dedup();
    int n, lat;
    logic [18:0] a;
    logic [9:0] px;
    logic [8:0] py;
    push_sample(10'd512, 10'd384, n, lat, a, px, py);
    total_cnt++; if (n !== 0) $display("FAIL dedup_same_addr: got %0d accepts want 0", n); else pass_cnt++;
    gap(20);
    push_sample(10'd520, 10'd384, n, lat, a, px, py);
    total_cnt++; if (n !== 1) $display("FAIL dedup_new_accepts: got %0d want 1", n); else pass_cnt++;
    total_cnt++; if (px !== 10'd321) $display("FAIL dedup_pix_x: got %0d want 321", px); else pass_cnt++;
    total_cnt++; if (a !== 19'd153921) $display("FAIL dedup_pix_addr: got %0d want 153921", a); else pass_cnt++;
    gap(20);
  endtask

  task automatic test_pen_up();
    int n, lat;
    logic [18:0] a;
    logic [9:0] px;
    logic [8:0] py;
    for (int i = 1; i <= 3; i++) begin
      push_sample(10'd1023, 10'd1023, n, lat, a, px, py);
      if (i == 2) begin
        total_cnt++; if (pen_down !== 1'b1) $display("FAIL penup_before_limit: got %0d want 1", pen_down); else pass_cnt++;
      end
      gap(10);
    end
    total_cnt++; if (pen_down !== 1'b0) $display("FAIL penup_pen_down: got %0d want 0", pen_down); else pass_cnt++;
    for (int i = 1; i <= 4; i++) begin
      push_sample(10'd100, 10'd200, n, lat, a, px, py);
      if (i < 4) begin
        total_cnt++; if (n !== 0) $display("FAIL penup_refill_%0d: got %0d accepts want 0", i, n); else pass_cnt++;
      end else begin
        total_cnt++; if (n !== 1) $display("FAIL penup_emit_accepts: got %0d want 1", n); else pass_cnt++;
        total_cnt++; if (a !== 19'd80062) $display("FAIL penup_emit_addr: got %0d want 80062", a); else pass_cnt++;
        total_cnt++; if (pen_down !== 1'b1) $display("FAIL penup_pen_down_again: got %0d want 1", pen_down); else pass_cnt++;
      end
      gap(10);
    end
  endtask

  task automatic test_back_pressure();
    int n, lat, unstable, acc;
    logic [18:0] a;
    logic [9:0] px;
    logic [8:0] py;
    total_cnt++; if (drop_count !== 8'd0) $display("FAIL bp_drop_before: got %0d want 0", drop_count); else pass_cnt++;
    pif.pix_ready = 1'b0;
    push_sample(10'd104, 10'd200, n, lat, a, px, py);
    total_cnt++; if (pif.pix_valid !== 1'b1) $display("FAIL bp_pending: got %0d want 1", pif.pix_valid); else pass_cnt++;
    total_cnt++; if (pif.pix_addr !== 19'd80063) $display("FAIL bp_pix_addr: got %0d want 80063", pif.pix_addr); else pass_cnt++;
    total_cnt++; if (pif.pix_x !== 10'd63) $display("FAIL bp_pix_x: got %0d want 63", pif.pix_x); else pass_cnt++;
    unstable = 0;
    for (int c = 1; c <= 500; c++) begin
      if (c == 100) begin
        cam_x = 10'd900; cam_y = 10'd100; cam_valid = 1'b1;
      end else if (c == 200) begin
        cam_x = 10'd1023; cam_y = 10'd1023; cam_valid = 1'b1;
      end else if (c == 300) begin
        cam_x = 10'd10; cam_y = 10'd10; cam_valid = 1'b1;
      end else begin
        cam_valid = 1'b0;
      end
      step();
      if (pif.pix_valid !== 1'b1 || pif.pix_addr !== 19'd80063 ||
          pif.pix_x !== 10'd63 || pif.pix_y !== 9'd125) unstable++;
    end
    cam_valid = 1'b0;
    total_cnt++; if (unstable !== 0) $display("FAIL bp_stable: got %0d unstable cycles want 0", unstable); else pass_cnt++;
    total_cnt++; if (drop_count !== 8'd3) $display("FAIL bp_drop_count: got %0d want 3", drop_count); else pass_cnt++;
    // Release ready together with a sample on the accepting cycle.
    cam_x = 10'd600;
    cam_y = 10'd600;
    cam_valid = 1'b1;
    pif.pix_ready = 1'b1;
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      if (pif.pix_valid && pif.pix_ready) acc++;
      step();
      cam_valid = 1'b0;
    end
    $display("back-pressure release: accepts=%0d drops=%0d", acc, drop_count);
    total_cnt++; if (acc !== 1) $display("FAIL bp_one_accept: got %0d want 1", acc); else pass_cnt++;
    total_cnt++; if (drop_count !== 8'd4) $display("FAIL bp_drop_on_accept: got %0d want 4", drop_count); else pass_cnt++;
    total_cnt++; if (pif.pix_valid !== 1'b0) $display("FAIL bp_valid_after: got %0d want 0", pif.pix_valid); else pass_cnt++;
  endtask

  task automatic test_clamp_corners();
    int n, lat;
    logic [18:0] a;
    logic [9:0] px;
    logic [8:0] py;
    for (int i = 1; i <= 4; i++) begin
      push_sample(10'd1022, 10'd767, n, lat, a, px, py);
      gap(10);
    end
    total_cnt++; if (n !== 1) $display("FAIL corner_max_accepts: got %0d want 1", n); else pass_cnt++;
    total_cnt++; if (px !== 10'd638) $display("FAIL corner_max_x: got %0d want 638", px); else pass_cnt++;
    total_cnt++; if (py !== 9'd479) $display("FAIL corner_max_y: got %0d want 479", py); else pass_cnt++;
    total_cnt++; if (a !== 19'd307198) $display("FAIL corner_max_addr: got %0d want 307198", a); else pass_cnt++;
    for (int i = 1; i <= 4; i++) begin
      push_sample(10'd0, 10'd0, n, lat, a, px, py);
      gap(10);
    end
    total_cnt++; if (n !== 1) $display("FAIL corner_zero_accepts: got %0d want 1", n); else pass_cnt++;
    total_cnt++; if (a !== 19'd0) $display("FAIL corner_zero_addr: got %0d want 0", a); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    int n, lat;
    logic [18:0] a;
    logic [9:0] px;
    logic [8:0] py;
    pif.pix_ready = 1'b0;
    push_sample(10'd400, 10'd400, n, lat, a, px, py);
    total_cnt++; if (pif.pix_valid !== 1'b1) $display("FAIL areset_pending: got %0d want 1", pif.pix_valid); else pass_cnt++;
    total_cnt++; if (pif.pix_addr !== 19'd39742) $display("FAIL areset_pending_addr: got %0d want 39742", pif.pix_addr); else pass_cnt++;
    // Assert reset between rising edges and look before the next one.
    #3;
    reset_n = 1'b0;
    #1;
    $display("async reset asserted mid-request: pix_valid=%0d", pif.pix_valid);
    total_cnt++; if (pif.pix_valid !== 1'b0) $display("FAIL areset_valid_drop: got %0d want 0", pif.pix_valid); else pass_cnt++;
    total_cnt++; if (pif.pix_addr !== 19'd0) $display("FAIL areset_addr: got %0d want 0", pif.pix_addr); else pass_cnt++;
    total_cnt++; if (pen_down !== 1'b0) $display("FAIL areset_pen_down: got %0d want 0", pen_down); else pass_cnt++;
    total_cnt++; if (drop_count !== 8'd0) $display("FAIL areset_drop_count: got %0d want 0", drop_count); else pass_cnt++;
    step();
    step();
    reset_n = 1'b1;
    pif.pix_ready = 1'b1;
    gap(2);
    for (int i = 1; i <= 4; i++) begin
      push_sample(10'd400, 10'd400, n, lat, a, px, py);
      if (i < 4) begin
        total_cnt++; if (n !== 0) $display("FAIL areset_refill_%0d: got %0d accepts want 0", i, n); else pass_cnt++;
      end else begin
        total_cnt++; if (n !== 1) $display("FAIL areset_emit_accepts: got %0d want 1", n); else pass_cnt++;
        total_cnt++; if (a !== 19'd160250) $display("FAIL areset_emit_addr: got %0d want 160250", a); else pass_cnt++;
      end
      gap(10);
    end
  endtask

  initial begin
    test_reset();
    test_fill_emit();
    test_dedup();
    test_pen_up();
    test_back_pressure();
    test_clamp_corners();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
